crc8_transmitter: RTL and testbench
===================================

Name: crc8_transmitter

Overview:
- Upstream neighbour of the CRC-8 frame receiver.
- Accepts a BW-bit data word over a valid/ready handshake and computes its CRC-8 bit-serially, one bit per clock, MSB first.
- Presents the frame {data, crc} to the receiver's input, held until consumed.
- The receiver checks the frame by recomputing the remainder over all BW+CRC_BW bits; a correct frame yields remainder zero.

Parameters:
- BW, 40, data word width in bits; BW >= 2.
- CRC_BW, 8, CRC width in bits; fixed at 8 for this block.
- POLY, 8'h07, generator polynomial, implicit x^8 term omitted (x^8+x^2+x+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  BW  data word to protect.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_frame  output  BW+CRC_BW  frame: [BW+CRC_BW-1:CRC_BW] = data, [CRC_BW-1:0] = CRC.
- out_valid  output  1  out_frame is valid.
- out_ready  input  1  downstream accepts out_frame.

Behaviour:
- States: IDLE, CALC, HOLD.
- All state is registered; out_frame and out_valid are register outputs. in_ready = (state == IDLE), decoded combinationally.
- Reset (rst=1 at a clk edge): state=IDLE, bit counter=0, crc=0, shift register=0, out_frame=0, out_valid=0. Reset has priority over every other event.
- Reset mid-CALC or mid-HOLD aborts the word; it is not resent.
- IDLE:
  - On an edge with in_valid=1, the word is accepted.
  - in_data is latched into the data register and the shift register; crc is cleared to 0; counter is cleared to 0; state goes to CALC.
  - in_valid=0: stay in IDLE.
- CALC: each edge processes one bit, MSB first.
  - fb = crc[7] ^ shift[BW-1]
  - crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00)
  - shift <= shift << 1; counter increments.
  - On the edge processing bit index BW-1 (counter == BW-1): out_frame <= {data, crc_next}, out_valid <= 1, state goes to HOLD.
  - in_valid and out_ready are ignored in CALC.
- CRC conventions: init 0, no reflection, no final XOR. The value equals the remainder of data·x^8 mod POLY.
- HOLD:
  - out_frame and out_valid stay constant while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, out_frame keeps its value, state goes to IDLE.
- Latency:
  - Word accepted at edge N gives out_valid=1 after edge N+BW.
  - With out_ready tied high, in_ready is high again after edge N+BW+1.
  - Throughput: one word per BW+2 cycles.
- No bypass: in_valid during the HOLD→IDLE edge is not accepted.
- Data register is not modified outside IDLE. in_data changes after acceptance have no effect.

Optional Feature:
- Macro: CRC8_TX_ERR_INJECT_EN.
- Defined:
  - Adds input port err_inject (1 bit).
  - The value sampled at the accepting edge in IDLE is stored with the word.
  - If stored err_inject=1, bit 0 of the CRC field is inverted when out_frame is loaded. The receiver must then detect the error and output 0.
  - The stored flag clears on reset.
- Not defined:
  - No err_inject port.
  - CRC field is always the correct remainder.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_frame=0, in_ready=1 after release.
- Single words, BW=40, out_ready=1:
  - in_data=40'h0000000000 → out_frame=48'h000000000000.
  - in_data=40'h0000000001 → out_frame=48'h000000000107.
  - in_data=40'h0000000002 → CRC byte 8'h0E.
  - in_data=40'h0000000003 → CRC byte 8'h09.
  - In every case out_valid rises exactly 40 edges after the accepting edge.
- Backpressure: out_ready=0 for 10 cycles in HOLD with in_data changing and in_valid=1 → out_frame stable, in_ready=0, no second word accepted. Raise out_ready → one-cycle handoff, then IDLE.
- Back-to-back: in_valid held high with 3 distinct words, out_ready=1 → exactly 3 frames, each 42 cycles apart, CRCs correct. Loopback into the receiver reproduces each data word.
- Reset mid-CALC: assert rst 20 cycles after acceptance → immediate IDLE, out_valid never rises. The next word is computed correctly from crc=0.
- With CRC8_TX_ERR_INJECT_EN: in_data=40'h0000000001, err_inject=1 → out_frame=48'h000000000106, and the receiver outputs 0.

Source files
------------

// File: rtl/crc8_transmitter.sv
// CRC-8 frame transmitter: bit-serial, MSB-first CRC over a BW-bit word, frame {data, crc} held until consumed.
// Optional macro CRC8_TX_ERR_INJECT_EN adds err_inject, which flips bit 0 of the CRC field for that word.
module crc8_transmitter #(
  parameter int         BW     = 40,
  parameter int         CRC_BW = 8,
  parameter logic [7:0] POLY   = 8'h07
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef CRC8_TX_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  output logic [BW+CRC_BW-1:0] out_frame,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int               CNT_W    = $clog2(BW);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BW-1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t              state;
  logic [BW-1:0]       data_q;
  logic [BW-1:0]       shift_q;
  logic [CRC_BW-1:0]   crc_q;
  logic [CRC_BW-1:0]   crc_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_flip;

  // One LFSR step of the non-reflected, zero-init CRC.
  function automatic logic [CRC_BW-1:0] crc_step(input logic [CRC_BW-1:0] crc,
                                                 input logic              din);
    logic fb;
    fb = crc[CRC_BW-1] ^ din;
    return {crc[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : {CRC_BW{1'b0}});
  endfunction

  assign crc_nxt  = crc_step(crc_q, shift_q[BW-1]);
  assign in_ready = (state == IDLE);

`ifdef CRC8_TX_ERR_INJECT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      err_q <= err_inject;
    end
  end

  assign err_flip = err_q;
`else
  assign err_flip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      shift_q   <= '0;
      out_frame <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            shift_q <= in_data;
            crc_q   <= '0;
            cnt_q   <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          crc_q   <= crc_nxt;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          // Last data bit: crc_nxt already holds the full remainder.
          if (cnt_q == LAST_BIT) begin
            out_frame <= {data_q, crc_nxt ^ {{(CRC_BW-1){1'b0}}, err_flip}};
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_transmitter.sv
// Scoreboard bench for crc8_transmitter: expected frames queued on acceptance, compared when out_valid rises.
module tb_crc8_transmitter;

  localparam int BW = 40;
  localparam int FW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_frame;
  logic          out_valid;
  logic          out_ready;
  logic          err_inject = 1'b0;

  crc8_transmitter #(.BW(BW), .CRC_BW(8), .POLY(8'h07)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef CRC8_TX_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .out_frame (out_frame),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] frame;
    int            cyc;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [FW-1:0] last_frame = '1;
  logic [FW-1:0] prev_frame = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          b2b = 1'b0;
  int            n_b2b = 0;
  int            last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Polynomial long division by x^8+x^2+x+1 over a 48-bit message.
  function automatic logic [7:0] rem48(input logic [FW-1:0] m);
    logic [FW-1:0] r;
    r = m;
    for (int i = FW-1; i >= 8; i--)
      if (r[i]) r = r ^ (48'h107 << (i-8));
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.frame = {in_data, rem48({in_data, 8'h00}) ^ {7'b0, err_inject}};
        e.cyc   = cyc + 1;
        e.err   = err_inject;
        sb.push_back(e);
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("frame", out_frame, e.frame);
          check_eq("latency", cyc - e.cyc, BW);
          check_eq("rx_rem_zero", rem48(out_frame) == 8'h00, !e.err);
          if (b2b) begin
            if (n_b2b > 0) check_eq("b2b_gap", cyc - last_rise, BW + 2);
            n_b2b++;
          end
          last_rise  = cyc;
          last_frame = out_frame;
        end
      end
      if (out_valid && prev_valid && !prev_ready)
        check_eq("hold_stable", out_frame, prev_frame);
      if (out_valid)
        check_eq("hold_in_ready", in_ready, 0);
      prev_valid = out_valid;
    end
    prev_frame = out_frame;
    prev_ready = out_ready;
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [BW-1:0] d);
    @(posedge clk);
    #1;
    in_data  = d;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0]   rnd;
    logic [BW-1:0] words [3];
    bit            seen;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 40'h00_0000_DEAD;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_frame", out_frame, 0);
    check_eq("rst_in_ready", in_ready, 1);

    send(40'h00_0000_0000); wait_idle(); check_eq("frm_zero", last_frame, 48'h0);
    send(40'h00_0000_0001); wait_idle(); check_eq("frm_one", last_frame, 48'h0000_0000_0107);
    send(40'h00_0000_0002); wait_idle(); check_eq("crc_two", last_frame[7:0], 8'h0E);
    send(40'h00_0000_0003); wait_idle(); check_eq("crc_three", last_frame[7:0], 8'h09);
    send(40'hA5_5A_C3_3C_81); wait_idle();
    send(40'hFF_FFFF_FFFF); wait_idle();

    // Backpressure with in_valid held and in_data wandering.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data  = 40'h80_0000_0005;
    in_valid = 1'b1;
    wait_accept();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check_eq("bp_valid_seen", seen, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      rnd     = {$urandom, $urandom};
      in_data = rnd[BW-1:0];
    end
    @(negedge clk);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_frame", out_frame, {40'h80_0000_0005, rem48({40'h80_0000_0005, 8'h00})});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_handoff_valid", out_valid, 0);
    check_eq("bp_handoff_ready", in_ready, 1);
    check_eq("bp_frame_kept", out_frame, last_frame);
    check_eq("bp_no_second", sb.size(), 0);

    // Back-to-back with in_valid held high.
    words[0] = 40'h12_3456_789A;
    words[1] = 40'hDE_ADBE_EF01;
    words[2] = 40'h00_FF00_FF00;
    b2b   = 1'b1;
    n_b2b = 0;
    @(posedge clk);
    #1;
    in_data  = words[0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept();
      if (k < 2) in_data = words[k+1];
      else       in_valid = 1'b0;
    end
    wait_idle();
    b2b = 1'b0;
    check_eq("b2b_count", n_b2b, 3);
    check_eq("b2b_last_data", last_frame[FW-1:8], words[2]);

    // Reset 20 cycles into CALC aborts the word.
    send(40'h5A_5A5A_5A5A);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    repeat (60) @(negedge clk);
    send(40'h5A_5A5A_5A5A); wait_idle();
    check_eq("after_abort_frame", last_frame, {40'h5A_5A5A_5A5A, rem48({40'h5A_5A5A_5A5A, 8'h00})});

`ifdef CRC8_TX_ERR_INJECT_EN
    @(posedge clk);
    #1;
    err_inject = 1'b1;
    send(40'h00_0000_0001);
    err_inject = 1'b0;
    wait_idle();
    check_eq("err_frame", last_frame, 48'h0000_0000_0106);
    send(40'h00_0000_0001); wait_idle();
    check_eq("err_cleared", last_frame, 48'h0000_0000_0107);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
